// File: rtl/sya_pe_bank_ctrl.sv
// Sequencer for the output-stationary systolic PE bank: takes a K-step tile job, skews act/wgt
// into the array, drives per-PE En/Reset along the diagonals, then drains and offers the tile.
module sya_pe_bank_ctrl #(
    parameter int NUM_ROW   = 16,
    parameter int NUM_COL   = 16,
    parameter int ACT_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int CHN_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           CfgVld,
    output logic                           CfgRdy,
    input  logic [CHN_WIDTH-1:0]           CfgNumChn,
    input  logic                           InActVld,
    output logic                           InActRdy,
    input  logic [NUM_ROW*ACT_WIDTH-1:0]   InAct,
    input  logic                           InWgtVld,
    output logic                           InWgtRdy,
    input  logic [NUM_COL*WGT_WIDTH-1:0]   InWgt,
    output logic [NUM_ROW*ACT_WIDTH-1:0]   OutAct_W,
    output logic [NUM_COL*WGT_WIDTH-1:0]   OutWgt_N,
    output logic [NUM_ROW*NUM_COL-1:0]     En,
    output logic [NUM_ROW*NUM_COL-1:0]     Reset,
    output logic                           PsumVld,
    input  logic                           PsumRdy
);
    // state | meaning
    // IDLE  | waiting for a job, CfgRdy high
    // FEED  | consuming one act/wgt vector pair per step
    // DRAIN | flushing skew pipes and the last PE MAC
    // OUT   | bank holds the finished tile until PsumRdy

    localparam int NUM_DIAG = NUM_ROW + NUM_COL - 1;
    localparam int DRN_W    = $clog2(NUM_ROW + NUM_COL);
    // Last fire to PsumVld spans NUM_ROW+NUM_COL cycles; one of them is the fire cycle itself.
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(NUM_ROW + NUM_COL - 2);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;

    state_t                state;
    logic [CHN_WIDTH-1:0]  stepCnt;
    logic [DRN_W-1:0]      drainCnt;
    logic                  firstPend;
    logic                  advQ;
    logic [NUM_DIAG-1:0]   tok;
    logic [NUM_DIAG-1:0]   first;
    logic                  fire;
    logic                  adv;

    assign fire     = (state == FEED) && InActVld && InWgtVld;
    assign adv      = fire || (state == DRAIN);
    assign CfgRdy   = (state == IDLE);
    assign InActRdy = (state == FEED) && InWgtVld;
    assign InWgtRdy = (state == FEED) && InActVld;
    assign PsumVld  = (state == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stepCnt   <= '0;
            drainCnt  <= '0;
            firstPend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CfgVld && (CfgNumChn != '0)) begin
                        stepCnt   <= CfgNumChn - 1'b1;
                        firstPend <= 1'b1;
                        state     <= FEED;
                    end
                end
                FEED: begin
                    if (fire) begin
                        firstPend <= 1'b0;
                        if (stepCnt == '0) begin
                            drainCnt <= DRN_LOAD;
                            state    <= DRAIN;
                        end else begin
                            stepCnt <= stepCnt - 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drainCnt == '0) state <= OUT;
                    else                drainCnt <= drainCnt - 1'b1;
                end
                OUT: begin
                    if (PsumRdy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything downstream of the input advances only together, so a stall freezes all diagonals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            advQ  <= 1'b0;
            tok   <= '0;
            first <= '0;
        end else begin
            advQ <= adv;
            if (adv) begin
                tok[0]   <= fire;
                first[0] <= fire && firstPend;
                for (int d = 1; d < NUM_DIAG; d++) begin
                    tok[d]   <= tok[d-1];
                    first[d] <= first[d-1];
                end
            end
        end
    end

    always_comb begin
        En    = '0;
        Reset = '0;
        for (int r = 0; r < NUM_ROW; r++) begin
            for (int c = 0; c < NUM_COL; c++) begin
                En[r*NUM_COL+c]    = advQ && tok[r+c];
                Reset[r*NUM_COL+c] = advQ && tok[r+c] && first[r+c];
            end
        end
    end

    // Zeros enter the pipes whenever no step fires, so idle lanes read 0.
    for (genvar r = 0; r < NUM_ROW; r++) begin : gActSkew
        logic [ACT_WIDTH-1:0] pipe [r+1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= r; i++) pipe[i] <= '0;
            end else if (adv) begin
                pipe[0] <= fire ? InAct[r*ACT_WIDTH +: ACT_WIDTH] : '0;
                for (int i = 1; i <= r; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign OutAct_W[r*ACT_WIDTH +: ACT_WIDTH] = pipe[r];
    end

    for (genvar c = 0; c < NUM_COL; c++) begin : gWgtSkew
        logic [WGT_WIDTH-1:0] pipe [c+1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= c; i++) pipe[i] <= '0;
            end else if (adv) begin
                pipe[0] <= fire ? InWgt[c*WGT_WIDTH +: WGT_WIDTH] : '0;
                for (int i = 1; i <= c; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign OutWgt_N[c*WGT_WIDTH +: WGT_WIDTH] = pipe[c];
    end

endmodule

// File: tb/tb_sya_pe_bank_ctrl.sv
// Directed bench for sya_pe_bank_ctrl on a 4x4 bank, with a behavioural PE array fed by the DUT.
module tb_sya_pe_bank_ctrl;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int AW = 8;
    localparam int WW = 8;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              CfgVld, CfgRdy;
    logic [CW-1:0]     CfgNumChn;
    logic              InActVld, InActRdy, InWgtVld, InWgtRdy;
    logic [R*AW-1:0]   InAct, OutAct_W;
    logic [C*WW-1:0]   InWgt, OutWgt_N;
    logic [R*C-1:0]    En, Reset;
    logic              PsumVld, PsumRdy;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    sya_pe_bank_ctrl #(.NUM_ROW(R), .NUM_COL(C), .ACT_WIDTH(AW), .WGT_WIDTH(WW), .CHN_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .CfgVld(CfgVld), .CfgRdy(CfgRdy), .CfgNumChn(CfgNumChn),
        .InActVld(InActVld), .InActRdy(InActRdy), .InAct(InAct),
        .InWgtVld(InWgtVld), .InWgtRdy(InWgtRdy), .InWgt(InWgt),
        .OutAct_W(OutAct_W), .OutWgt_N(OutWgt_N), .En(En), .Reset(Reset),
        .PsumVld(PsumVld), .PsumRdy(PsumRdy)
    );

    // Behavioural output-stationary bank: act passes W->E, wgt N->S, one register hop per PE.
    int         mAcc [R][C];
    logic [7:0] mAct [R][C];
    logic [7:0] mWgt [R][C];
    logic [7:0] mA, mW;
    int         prod;

    always @(posedge clk) begin
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (En[r*C+c]) begin
                    if (c == 0) mA = OutAct_W[r*AW +: AW];
                    else        mA = mAct[r][c-1];
                    if (r == 0) mW = OutWgt_N[c*WW +: WW];
                    else        mW = mWgt[r-1][c];
                    prod = int'(mA) * int'(mW);
                    mAcc[r][c] <= Reset[r*C+c] ? prod : mAcc[r][c] + prod;
                    mAct[r][c] <= mA;
                    mWgt[r][c] <= mW;
                end
            end
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] actVal(input int job, input int k, input int r);
        return 8'((job*37 + k*11 + r*5 + 3) % 256);
    endfunction

    function automatic logic [7:0] wgtVal(input int job, input int k, input int c);
        return 8'((job*53 + k*7 + c*13 + 1) % 256);
    endfunction

    task automatic driveStep(input int job, input int k, input logic av, input logic wv);
        InActVld = av;
        InWgtVld = wv;
        for (int r = 0; r < R; r++) InAct[r*AW +: AW] = actVal(job, k, r);
        for (int c = 0; c < C; c++) InWgt[c*WW +: WW] = wgtVal(job, k, c);
    endtask

    task automatic idleIn();
        InActVld = 1'b0;
        InWgtVld = 1'b0;
        InAct    = '0;
        InWgt    = '0;
    endtask

    // Leaves the caller just after the negedge of the first FEED cycle.
    task automatic startJob(input string tag, input int k);
        @(negedge clk);
        CfgVld    = 1'b1;
        CfgNumChn = CW'(k);
        #1;
        checkVal({tag, " cfgRdy"}, CfgRdy, 1);
        @(negedge clk);
        CfgVld = 1'b0;
    endtask

    task automatic checkPsum(input string tag, input int job, input int k);
        int gold;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                gold = 0;
                for (int s = 0; s < k; s++) gold += int'(actVal(job, s, r)) * int'(wgtVal(job, s, c));
                checkVal($sformatf("%s psum[%0d][%0d]", tag, r, c), 64'(mAcc[r][c]), 64'(gold));
            end
        end
    endtask

    task automatic waitPsum(input string tag, input int budget, output int n);
        n = 0;
        while (!PsumVld && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkVal({tag, " psumVld seen"}, PsumVld, 1);
    endtask

    task automatic takePsum(input string tag);
        @(negedge clk);
        PsumRdy = 1'b1;
        #1;
        checkVal({tag, " psumVld before take"}, PsumVld, 1);
        @(negedge clk);
        PsumRdy = 1'b0;
        #1;
        checkVal({tag, " idle after take"}, {CfgRdy, PsumVld}, 2'b10);
    endtask

    logic [15:0] en00, en33, en12, rst00, rst33, pv, enAny, rdy;
    logic [7:0]  lane;
    logic        accA, accB, accC;
    int          n;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        CfgVld = 1'b0; CfgNumChn = '0; PsumRdy = 1'b0;
        driveStep(0, 0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        checkVal("reset cfgRdy", CfgRdy, 1);
        checkVal("reset en/reset", {En, Reset}, 0);
        checkVal("reset psumVld", PsumVld, 0);
        checkVal("reset inRdy", {InActRdy, InWgtRdy}, 0);
        checkVal("reset skew out", {OutAct_W, OutWgt_N}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idleIn();

        // 1: K=3, no stalls
        startJob("t1", 3);
        driveStep(1, 0, 1'b1, 1'b1);
        #1;
        checkVal("t1 actRdy", {InActRdy, InWgtRdy}, 2'b11);
        checkVal("t1 cfgRdy in feed", CfgRdy, 0);
        {en00, en33, en12, rst00, rst33, pv} = '0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j < 3) driveStep(1, j, 1'b1, 1'b1);
            else       idleIn();
            #1;
            en00[j-1] = En[0]; en33[j-1] = En[15]; en12[j-1] = En[1*C+2];
            rst00[j-1] = Reset[0]; rst33[j-1] = Reset[15]; pv[j-1] = PsumVld;
            if (j == 4) lane = OutAct_W[3*AW +: AW];
        end
        checkVal("t1 en00", en00, 16'h0007);
        checkVal("t1 en33", en33, 16'h01C0);
        checkVal("t1 en12", en12, 16'h0038);
        checkVal("t1 rst00", rst00, 16'h0001);
        checkVal("t1 rst33", rst33, 16'h0040);
        checkVal("t1 psumVld", pv, 16'hFE00);
        checkVal("t1 act row3 skew", lane, actVal(1, 0, 3));
        checkPsum("t1", 1, 3);
        takePsum("t1");

        // 2: weight gap of 2 cycles after step 0
        startJob("t2", 3);
        driveStep(2, 0, 1'b1, 1'b1);
        {en00, en33, rst33, pv, enAny, rdy} = '0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j < 3)       driveStep(2, 1, 1'b1, 1'b0);
            else if (j == 3) driveStep(2, 1, 1'b1, 1'b1);
            else if (j == 4) driveStep(2, 2, 1'b1, 1'b1);
            else             idleIn();
            #1;
            en00[j-1] = En[0]; en33[j-1] = En[15]; rst33[j-1] = Reset[15];
            pv[j-1] = PsumVld; enAny[j-1] = |En; rdy[j-1] = InActRdy;
            if (j == 1) checkVal("t2 wgtRdy in gap", InWgtRdy, 1);
            if (j == 3) lane = OutAct_W[0 +: AW];
        end
        checkVal("t2 actRdy", rdy, 16'h000C);
        checkVal("t2 en any", enAny, 16'h07F9);
        checkVal("t2 en00", en00, 16'h0019);
        checkVal("t2 en33", en33, 16'h0700);
        checkVal("t2 rst33", rst33, 16'h0100);
        checkVal("t2 psumVld", pv, 16'hF800);
        checkVal("t2 act row0 held", lane, actVal(2, 0, 0));
        checkPsum("t2", 2, 3);
        takePsum("t2");

        // 3: K=0 consumed without work, then K=1
        @(negedge clk);
        CfgVld = 1'b1; CfgNumChn = '0;
        #1;
        checkVal("t3 cfgRdy k0", CfgRdy, 1);
        accA = 1'b0; accB = 1'b0; accC = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            CfgVld = 1'b0;
            #1;
            accA |= |En; accB |= PsumVld; accC &= CfgRdy;
        end
        checkVal("t3 k0 no en/psum", {accA, accB}, 0);
        checkVal("t3 k0 stays idle", accC, 1);
        startJob("t3", 1);
        driveStep(3, 0, 1'b1, 1'b1);
        {en00, rst00, pv} = '0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            idleIn();
            #1;
            en00[j-1] = En[0]; rst00[j-1] = Reset[0]; pv[j-1] = PsumVld;
        end
        checkVal("t3 en00", en00, 16'h0001);
        checkVal("t3 rst00", rst00, 16'h0001);
        checkVal("t3 psumVld", pv, 16'h0380);
        checkPsum("t3", 3, 1);

        // 4: downstream holds off for 5 cycles while a new cfg is offered
        accA = 1'b1; accB = 1'b0; accC = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            CfgVld = 1'b1; CfgNumChn = 16'd5;
            #1;
            accA &= PsumVld; accB |= CfgRdy; accC |= |En;
        end
        CfgVld = 1'b0;
        checkVal("t4 psumVld held", accA, 1);
        checkVal("t4 cfgRdy low", accB, 0);
        checkVal("t4 no en", accC, 0);
        takePsum("t4");

        // 5: reset in the middle of FEED, then a fresh K=2 job
        startJob("t5", 3);
        driveStep(4, 0, 1'b1, 1'b1);
        @(negedge clk);
        driveStep(4, 1, 1'b1, 1'b1);
        #1;
        checkVal("t5 en00 before reset", En[0], 1);
        rst_n = 1'b0;
        #1;
        checkVal("t5 en/reset cleared", {En, Reset}, 0);
        checkVal("t5 psumVld/rdy cleared", {PsumVld, InActRdy, InWgtRdy}, 0);
        checkVal("t5 skew cleared", {OutAct_W, OutWgt_N}, 0);
        checkVal("t5 cfgRdy in reset", CfgRdy, 1);
        @(negedge clk);
        idleIn();
        rst_n = 1'b1;
        startJob("t5b", 2);
        driveStep(5, 0, 1'b1, 1'b1);
        @(negedge clk);
        driveStep(5, 1, 1'b1, 1'b1);
        @(negedge clk);
        idleIn();
        #1;
        waitPsum("t5", 30, n);
        checkVal("t5 psum latency", n, 7);
        checkPsum("t5", 5, 2);
        takePsum("t5");

        // 6: act valid alone for 10 cycles
        startJob("t6", 1);
        accA = 1'b0; accB = 1'b0; accC = 1'b0;
        for (int j = 0; j < 10; j++) begin
            driveStep(6, 0, 1'b1, 1'b0);
            #1;
            accA |= InActRdy; accB |= |En; accC |= CfgRdy;
            @(negedge clk);
        end
        checkVal("t6 actRdy low", accA, 0);
        checkVal("t6 no en", accB, 0);
        checkVal("t6 no idle", accC, 0);
        driveStep(6, 0, 1'b1, 1'b1);
        #1;
        checkVal("t6 still feeding", InActRdy, 1);
        @(negedge clk);
        idleIn();
        #1;
        waitPsum("t6", 30, n);
        checkVal("t6 psum latency", n, 7);
        checkPsum("t6", 6, 1);
        takePsum("t6");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
